// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter, start / data LSB-first / [parity] / stop.
// Define UART_TX_PARITY_EN to insert the parity bit (polarity PARITY_ODD).
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 234,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DATA_BITS - 1);
    localparam logic          STP_MAX = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("DATA_BITS must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_sb
        $error("STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
        $error("PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP
    } state_t;
`endif

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic                 stp;
    logic [DATA_BITS-1:0] shreg;
    logic                 tick;
`ifdef UART_TX_PARITY_EN
    logic                 par;
`endif

    assign tick     = (cnt == CNT_MAX);
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_done <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
            stp     <= 1'b0;
            shreg   <= '0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            if (state != IDLE) begin
                cnt <= tick ? '0 : cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (in_valid) begin
                        shreg <= in_data;
                        cnt   <= '0;
                        idx   <= '0;
                        stp   <= 1'b0;
                        state <= START;
                        tx    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        par   <= (^in_data) ^ (PARITY_ODD != 0);
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        state <= DATA;
                        idx   <= '0;
                        tx    <= shreg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= shreg >> 1;
                        if (idx == IDX_MAX) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= par;
`else
                            state <= STOP;
                            stp   <= 1'b0;
                            tx    <= 1'b1;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                            tx  <= shreg[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state <= STOP;
                        stp   <= 1'b0;
                        tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    tx <= 1'b1;
                    if (tick) begin
                        if (stp == STP_MAX) begin
                            state   <= IDLE;
                            tx_done <= 1'b1;
                        end else begin
                            stp <= stp + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule
